// File: rtl/flush_ctrl_if.sv
// Flush-controller bundle: WB flush causes, fetch handshake events, and
// the redirect/flush outputs back to the front end.
interface flush_ctrl_if #(
  parameter int OSTD_W = 2
);
  logic              wb_ex;
  logic              ertn_flush;
  logic              wb_refetch_flush;
  logic [31:0]       wb_flush_entry;
  logic              inst_req_fire;
  logic              inst_resp_fire;
  logic              redirect_ready;
  logic              flush_pipe;
  logic              inst_req_block;
  logic              discard_resp;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [1:0]        flush_cause;
  logic [OSTD_W-1:0] ostd_cnt;
  logic              ostd_ovf;

  modport slave (
    input  wb_ex, ertn_flush, wb_refetch_flush, wb_flush_entry,
           inst_req_fire, inst_resp_fire, redirect_ready,
    output flush_pipe, inst_req_block, discard_resp, redirect_valid,
           redirect_pc, flush_cause, ostd_cnt, ostd_ovf
  );

  modport master (
    output wb_ex, ertn_flush, wb_refetch_flush, wb_flush_entry,
           inst_req_fire, inst_resp_fire, redirect_ready,
    input  flush_pipe, inst_req_block, discard_resp, redirect_valid,
           redirect_pc, flush_cause, ostd_cnt, ostd_ovf
  );
endinterface

// File: rtl/flush_ctrl.sv
// Pipeline flush controller: clears the pipe, drains in-flight fetches,
// then hands the flush target to pre-IF as a redirect.
module flush_ctrl #(
  parameter int OSTD_W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  flush_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  localparam logic [OSTD_W-1:0] OSTD_MAX = '1;
  localparam logic [OSTD_W-1:0] ONE      = OSTD_W'(1);

  state_t            state;
  logic [OSTD_W-1:0] ostd_cnt, ostd_next, drain_cnt;
  logic              ostd_ovf, ovf_evt;
  logic [31:0]       target;
  logic [1:0]        cause, cause_in;
  logic              flush_req, inc, dec;

  assign flush_req = bus.wb_ex | bus.ertn_flush | bus.wb_refetch_flush;
  assign inc       = bus.inst_req_fire & ~bus.inst_resp_fire;
  assign dec       = bus.inst_resp_fire & ~bus.inst_req_fire;

  always_comb begin
    cause_in = 2'b00;
    if (bus.wb_ex)                 cause_in = 2'b01;
    else if (bus.ertn_flush)       cause_in = 2'b10;
    else if (bus.wb_refetch_flush) cause_in = 2'b11;
  end

  // Saturating counter; a fetch issued while blocked is still counted but flagged.
  always_comb begin
    ostd_next = ostd_cnt;
    ovf_evt   = bus.inst_req_fire & (state != IDLE);
    if (inc) begin
      if (ostd_cnt == OSTD_MAX) ovf_evt   = 1'b1;
      else                      ostd_next = ostd_cnt + ONE;
    end else if (dec) begin
      if (ostd_cnt == '0)       ovf_evt   = 1'b1;
      else                      ostd_next = ostd_cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ostd_cnt <= '0;
      ostd_ovf <= 1'b0;
    end else begin
      ostd_cnt <= ostd_next;
      if (ovf_evt) ostd_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= '0;
      target    <= '0;
      cause     <= 2'b00;
    end else if (flush_req) begin
      target    <= bus.wb_flush_entry;
      cause     <= cause_in;
      drain_cnt <= ostd_next;
      // A reflush during REDIRECT only retargets; fetches are already blocked.
      if (state != REDIRECT)
        state <= (ostd_next != '0) ? DRAIN : REDIRECT;
    end else begin
      case (state)
        DRAIN: begin
          if (bus.inst_resp_fire) begin
            if (drain_cnt <= ONE) begin
              state     <= REDIRECT;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - ONE;
            end
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            state <= IDLE;
            cause <= 2'b00;
          end
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational outputs are gated by resetn so they drop during reset.
  assign bus.flush_pipe     = resetn & flush_req;
  assign bus.discard_resp   = resetn & bus.inst_resp_fire & (flush_req | (state == DRAIN));
  assign bus.inst_req_block = (state != IDLE);
  assign bus.redirect_valid = resetn & (state == REDIRECT) & ~flush_req;
  assign bus.redirect_pc    = target;
  assign bus.flush_cause    = cause;
  assign bus.ostd_cnt       = ostd_cnt;
  assign bus.ostd_ovf       = ostd_ovf;
endmodule

// File: tb/tb_flush_ctrl.sv
// Self-checking bench for flush_ctrl: directed vector table, async-reset
// corner case, and randomized traffic against a behavioural model.
module tb_flush_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flush_ctrl_if #(.OSTD_W(2)) bus();
  flush_ctrl #(.OSTD_W(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic        rst;
    logic        ex, ertn, rf;
    logic [31:0] entry;
    logic        req, resp, rdy;
    logic        fp, blk, disc, rv;
    logic [31:0] rpc;
    logic [1:0]  cause;
    logic [1:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(logic rst, logic ex, logic ertn, logic rf, logic [31:0] entry,
                              logic req, logic resp, logic rdy,
                              logic fp, logic blk, logic disc, logic rv, logic [31:0] rpc,
                              logic [1:0] cause, logic [1:0] cnt, logic ovf);
    vec_t v;
    v.rst = rst; v.ex = ex; v.ertn = ertn; v.rf = rf; v.entry = entry;
    v.req = req; v.resp = resp; v.rdy = rdy;
    v.fp = fp; v.blk = blk; v.disc = disc; v.rv = rv; v.rpc = rpc;
    v.cause = cause; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ex, input logic ertn, input logic rf, input logic [31:0] entry,
                       input logic req, input logic resp, input logic rdy);
    bus.wb_ex = ex; bus.ertn_flush = ertn; bus.wb_refetch_flush = rf;
    bus.wb_flush_entry = entry; bus.inst_req_fire = req;
    bus.inst_resp_fire = resp; bus.redirect_ready = rdy;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic step_none();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_ostd;
  bit          m_ovf;
  bit          m_pending;   // a flush has been taken and not yet redirected
  int          m_wait;      // responses still to be swallowed before redirect
  logic [31:0] m_tgt;
  logic [1:0]  m_cause;

  task automatic model_reset();
    m_ostd = 0; m_ovf = 0; m_pending = 0; m_wait = 0; m_tgt = 0; m_cause = 0;
  endtask

  task automatic model_check();
    bit fr;
    fr = bus.wb_ex | bus.ertn_flush | bus.wb_refetch_flush;
    chk("r_flush_pipe", 32'(bus.flush_pipe), 32'(fr));
    chk("r_req_block", 32'(bus.inst_req_block), 32'(m_pending));
    chk("r_discard", 32'(bus.discard_resp),
        32'(bus.inst_resp_fire && (fr || (m_pending && m_wait > 0))));
    chk("r_redir_valid", 32'(bus.redirect_valid), 32'(m_pending && m_wait == 0 && !fr));
    if (m_pending && m_wait == 0 && !fr) chk("r_redir_pc", bus.redirect_pc, m_tgt);
    chk("r_cause", 32'(bus.flush_cause), 32'(m_cause));
    chk("r_ostd", 32'(bus.ostd_cnt), 32'(m_ostd));
    chk("r_ovf", 32'(bus.ostd_ovf), 32'(m_ovf));
  endtask

  task automatic model_update();
    bit fr;
    int delta;
    fr = bus.wb_ex | bus.ertn_flush | bus.wb_refetch_flush;
    delta = int'(bus.inst_req_fire) - int'(bus.inst_resp_fire);
    if (bus.inst_req_fire && m_pending) m_ovf = 1;
    if (m_ostd + delta > 3 || m_ostd + delta < 0) m_ovf = 1;
    else m_ostd = m_ostd + delta;
    if (fr) begin
      m_tgt   = bus.wb_flush_entry;
      m_cause = bus.wb_ex ? 2'd1 : bus.ertn_flush ? 2'd2 : 2'd3;
      if (!(m_pending && m_wait == 0)) m_wait = m_ostd;
      m_pending = 1;
    end else if (m_pending && m_wait > 0) begin
      if (bus.inst_resp_fire) m_wait--;
    end else if (m_pending && bus.redirect_ready) begin
      m_pending = 0;
      m_cause   = 0;
    end
  endtask

  initial begin
    // rst ex ertn rf entry req resp rdy | fp blk disc rv rpc cause cnt ovf
    vt[0]  = mk(0,0,0,0,32'h0,       0,0,0, 0,0,0,0,32'h0,       0,0,0);
    vt[1]  = mk(0,1,0,0,32'h1C000000,0,0,0, 1,0,0,0,32'h0,       0,0,0);
    vt[2]  = mk(0,0,0,0,32'h0,       0,0,1, 0,1,0,1,32'h1C000000,1,0,0);
    vt[3]  = mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,0,0);
    vt[4]  = mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,1,0);
    vt[5]  = mk(0,0,1,0,32'h80,      0,0,0, 1,0,0,0,32'h0,       0,2,0);
    vt[6]  = mk(0,0,0,0,32'h0,       0,1,0, 0,1,1,0,32'h0,       2,2,0);
    vt[7]  = mk(0,0,0,0,32'h0,       0,0,0, 0,1,0,0,32'h0,       2,1,0);
    vt[8]  = mk(0,0,0,0,32'h0,       0,1,0, 0,1,1,0,32'h0,       2,1,0);
    vt[9]  = mk(0,0,0,0,32'h0,       0,0,0, 0,1,0,1,32'h80,      2,0,0);
    vt[10] = mk(0,0,0,0,32'h0,       0,0,1, 0,1,0,1,32'h80,      2,0,0);
    vt[11] = mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,0,0);
    vt[12] = mk(0,0,0,1,32'h100,     1,1,0, 1,0,1,0,32'h0,       0,1,0);
    vt[13] = mk(0,0,0,0,32'h0,       0,1,0, 0,1,1,0,32'h0,       3,1,0);
    vt[14] = mk(0,1,0,0,32'h200,     0,0,1, 1,1,0,0,32'h0,       3,0,0);
    vt[15] = mk(0,0,0,0,32'h0,       0,0,0, 0,1,0,1,32'h200,     1,0,0);
    vt[16] = mk(0,0,0,0,32'h0,       0,0,1, 0,1,0,1,32'h200,     1,0,0);
    vt[17] = mk(0,0,0,0,32'h0,       0,1,0, 0,0,0,0,32'h0,       0,0,0);
    vt[18] = mk(0,0,0,0,32'h0,       0,0,0, 0,0,0,0,32'h0,       0,0,1);
    vt[19] = mk(1,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,0,0);
    vt[20] = mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,1,0);
    vt[21] = mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,2,0);
    vt[22] = mk(0,0,0,0,32'h0,       1,0,0, 0,0,0,0,32'h0,       0,3,0);
    vt[23] = mk(0,0,0,0,32'h0,       0,0,0, 0,0,0,0,32'h0,       0,3,1);

    drive(0, 0, 0, 32'h0, 0, 0, 0);
    #2 chk("reset_block", 32'(bus.inst_req_block), 32'h0);
    chk("reset_ostd", 32'(bus.ostd_cnt), 32'h0);
    chk("reset_pc", bus.redirect_pc, 32'h0);
    do_reset();

    for (int i = 0; i < 24; i++) begin
      if (vt[i].rst) do_reset();
      drive(vt[i].ex, vt[i].ertn, vt[i].rf, vt[i].entry, vt[i].req, vt[i].resp, vt[i].rdy);
      #1;
      chk($sformatf("v%0d_flush_pipe", i), 32'(bus.flush_pipe), 32'(vt[i].fp));
      chk($sformatf("v%0d_req_block", i), 32'(bus.inst_req_block), 32'(vt[i].blk));
      chk($sformatf("v%0d_discard", i), 32'(bus.discard_resp), 32'(vt[i].disc));
      chk($sformatf("v%0d_redir_valid", i), 32'(bus.redirect_valid), 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("v%0d_redir_pc", i), bus.redirect_pc, vt[i].rpc);
      chk($sformatf("v%0d_cause", i), 32'(bus.flush_cause), 32'(vt[i].cause));
      chk($sformatf("v%0d_ostd", i), 32'(bus.ostd_cnt), 32'(vt[i].cnt));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ostd_ovf), 32'(vt[i].ovf));
      @(posedge clk);
      #1;
    end

    // Async reset while draining, with flush/resp inputs still asserted.
    do_reset();
    drive(0, 0, 0, 32'h0, 1, 0, 0); step_none();
    drive(0, 0, 0, 32'h0, 1, 0, 0); step_none();
    drive(1, 0, 0, 32'h33, 0, 0, 0); step_none();
    drive(1, 0, 0, 32'h55, 0, 1, 1);
    #1;
    chk("ar_pre_block", 32'(bus.inst_req_block), 32'h1);
    chk("ar_pre_discard", 32'(bus.discard_resp), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_flush_pipe", 32'(bus.flush_pipe), 32'h0);
    chk("ar_block", 32'(bus.inst_req_block), 32'h0);
    chk("ar_discard", 32'(bus.discard_resp), 32'h0);
    chk("ar_redir_valid", 32'(bus.redirect_valid), 32'h0);
    chk("ar_redir_pc", bus.redirect_pc, 32'h0);
    chk("ar_cause", 32'(bus.flush_cause), 32'h0);
    chk("ar_ostd", 32'(bus.ostd_cnt), 32'h0);
    chk("ar_ovf", 32'(bus.ostd_ovf), 32'h0);
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(1, 0, 0, 32'h44, 0, 0, 0);
    #1;
    chk("ar_post_block", 32'(bus.inst_req_block), 32'h0);
    chk("ar_post_ostd", 32'(bus.ostd_cnt), 32'h0);
    step_none();
    drive(0, 0, 0, 32'h0, 0, 0, 1);
    #1;
    chk("ar_post_redir_valid", 32'(bus.redirect_valid), 32'h1);
    chk("ar_post_redir_pc", bus.redirect_pc, 32'h44);
    step_none();

    // Randomized traffic against the model.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
        logic ex, er, rf, rq, rs, rd;
        ex = ($urandom_range(0, 99) < 5);
        er = ($urandom_range(0, 99) < 4);
        rf = ($urandom_range(0, 99) < 4);
        rq = m_pending ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 35);
        rs = (m_ostd > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3);
        rd = ($urandom_range(0, 99) < 50);
        drive(ex, er, rf, $urandom(), rq, rs, rd);
        #1;
        model_check();
        @(posedge clk);
        model_update();
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
